frame_tx_scheduler: RTL and testbench
=====================================

FRAME_TX_SCHEDULER -- requirements
Module: frame_tx_scheduler

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- BYTES_PER_FRAME, 9216, bytes read out per frame.
- ADDR_W, 15, frame-buffer address width.
- SETTLE_CYCLES, 62500000, Clk cycles between frame trigger and first byte.
- GAP_CYCLES, 62500000, Clk cycles after last byte before re-arming.
- HEADER_BYTE, 8'hFF, sync byte sent before each frame.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- Clk  in  1  system clock; one clock domain only.
- i_Rst_n  in  1  reset, asynchronous, active-low.
- i_Enable  in  1  level; permits frame transfers.
- i_VS  in  1  camera vertical sync (asynchronous to Clk).
- o_Write_Inhibit  out  1  blocks camera writes into the frame buffer.
- o_Rd_En  out  1  frame-buffer read enable.
- o_Rd_Addr  out  ADDR_W  frame-buffer read address.
- i_Rd_Data  in  8  read data, valid 1 Clk after o_Rd_En.
- o_Tx_Start  out  1  one-cycle pulse; UART loads o_Tx_Byte.
- o_Tx_Byte  out  8  byte to transmit; held stable until i_Tx_Busy falls.
- i_Tx_Busy  in  1  UART busy; rises the cycle after o_Tx_Start.
- o_Frame_Indicator  out  1  high only in IDLE.
- o_Frame_Done  out  1  one-cycle pulse after the last byte completes.
- o_Busy  out  1  high in every state except IDLE.

Function
REQ-003 i_VS SHALL pass through a 2-flop synchronizer; the trigger is a 0->1 edge on the synchronized signal.
REQ-004 States SHALL be IDLE, SETTLE, HEADER, FETCH, LATCH, SEND, WAIT_TX, GAP.
REQ-005 IDLE->SETTLE SHALL occur on a trigger while i_Enable=1; triggers in other states are ignored.
REQ-006 o_Write_Inhibit SHALL rise on entry to SETTLE and fall on exit from GAP.
REQ-007 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to HEADER.
REQ-008 HEADER SHALL load HEADER_BYTE into o_Tx_Byte, pulse o_Tx_Start when i_Tx_Busy=0, then go to WAIT_TX.
REQ-009 FETCH SHALL assert o_Rd_En for 1 cycle at the current o_Rd_Addr; LATCH SHALL capture i_Rd_Data into o_Tx_Byte.
REQ-010 SEND SHALL pulse o_Tx_Start once i_Tx_Busy=0, then go to WAIT_TX.
REQ-011 WAIT_TX SHALL ignore i_Tx_Busy in its first cycle, then wait for i_Tx_Busy=0.
REQ-012 On WAIT_TX exit after the header, the next state SHALL be FETCH with o_Rd_Addr=0.
REQ-013 On WAIT_TX exit after a data byte with addr < BYTES_PER_FRAME-1: addr+1, then FETCH.
REQ-014 On WAIT_TX exit after addr = BYTES_PER_FRAME-1: pulse o_Frame_Done, clear addr to 0, go to GAP; addr never exceeds BYTES_PER_FRAME-1.
REQ-015 GAP SHALL last exactly GAP_CYCLES cycles, then go to IDLE.
REQ-016 If i_Enable=0 is sampled in WAIT_TX or GAP, the current byte SHALL finish, then: IDLE, addr=0, inhibit low, no o_Frame_Done.
REQ-017 i_Enable falling in SETTLE SHALL abort to IDLE on the next cycle.
REQ-018 A single counter SHALL serve SETTLE and GAP, sized for max(SETTLE_CYCLES, GAP_CYCLES); it clears on every state entry.
REQ-019 Every byte SHALL produce exactly one o_Tx_Start pulse; a frame produces BYTES_PER_FRAME+1 pulses.

Reset
REQ-020 i_Rst_n=0 SHALL immediately force: state IDLE, o_Rd_Addr=0, o_Tx_Byte=0, counter=0, synchronizer flops=0.
REQ-021 Output values during reset SHALL be: o_Frame_Indicator=1; o_Write_Inhibit, o_Rd_En, o_Tx_Start, o_Frame_Done, o_Busy all 0.
REQ-022 Reset mid-frame SHALL abandon the transfer without a completing pulse; the first trigger after release restarts at the header.

Structure
REQ-023 A shared package SHALL hold the state encoding, HEADER_BYTE, BYTES_PER_FRAME, and the UART clocks-per-bit constant (1085).
REQ-024 One sub-module, vs_edge_sync (synchronizer plus rising-edge detector), is natural; the FSM and counters SHALL stay in frame_tx_scheduler.

Verification
REQ-025 Use BYTES_PER_FRAME=4, SETTLE_CYCLES=10, GAP_CYCLES=8 and a UART model with busy 20 cycles; the bench SHALL cover:
- VS edge, Enable=1 -> inhibit high; first o_Tx_Start 11-13 cycles later carries 0xFF; bytes then follow in order from RAM addr 0,1,2,3.
- Full frame -> 5 o_Tx_Start pulses, one o_Frame_Done after the last busy falls, inhibit low 8 cycles later, o_Frame_Indicator=1.
- VS edge arriving during SEND/GAP -> no extra frame; a VS edge after the return to IDLE starts a new frame.
- Enable dropped during byte 2 busy -> byte 2 completes, IDLE, no o_Frame_Done, addr=0.
- i_Rst_n pulsed low mid-GAP -> outputs at reset values immediately; a new VS edge restarts with the 0xFF header.
- i_Tx_Busy held high 100 cycles -> no new o_Tx_Start until it falls; o_Tx_Byte stable throughout.

Source files
------------

// File: rtl/frame_tx_scheduler_pkg.sv
// frame_tx_scheduler_pkg: shared state encoding and frame/UART constants for the frame transmit scheduler
package frame_tx_scheduler_pkg;
    typedef enum logic [2:0] {
        IDLE, SETTLE, HEADER, FETCH, LATCH, SEND, WAIT_TX, GAP
    } state_t;
    localparam logic [7:0] HEADER_BYTE       = 8'hFF;
    localparam int         BYTES_PER_FRAME   = 9216;
    localparam int         UART_CLKS_PER_BIT = 1085;
endpackage

// File: rtl/vs_edge_sync.sv
// vs_edge_sync: 2-flop synchronizer for camera vsync plus rising-edge detector
//   Clk     - system clock
//   i_Rst_n - asynchronous active-low reset, clears all flops
//   i_VS    - vsync, asynchronous to Clk
//   o_Rise  - one-cycle pulse on a 0->1 edge of the synchronized vsync
module vs_edge_sync (
    input  logic Clk,
    input  logic i_Rst_n,
    input  logic i_VS,
    output logic o_Rise
);
    logic [2:0] sync_q;

    always_ff @(posedge Clk or negedge i_Rst_n)
        if (!i_Rst_n) sync_q <= '0;
        else          sync_q <= {sync_q[1:0], i_VS};

    assign o_Rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler: on vsync, freezes the frame buffer and streams a header byte plus the frame over a UART
//   Clk, i_Rst_n        - clock, asynchronous active-low reset
//   i_Enable            - level, permits frame transfers
//   i_VS                - camera vsync (asynchronous)
//   o_Write_Inhibit     - blocks camera writes while a frame is being read out
//   o_Rd_En, o_Rd_Addr  - frame-buffer read port; i_Rd_Data valid one cycle after o_Rd_En
//   o_Tx_Start, o_Tx_Byte, i_Tx_Busy - UART load handshake
//   o_Frame_Indicator   - high in IDLE; o_Busy - high outside IDLE
//   o_Frame_Done        - one-cycle pulse when the last byte of a frame completes
module frame_tx_scheduler
    import frame_tx_scheduler_pkg::*;
#(
    parameter int         BYTES_PER_FRAME = frame_tx_scheduler_pkg::BYTES_PER_FRAME,
    parameter int         ADDR_W          = 15,
    parameter int         SETTLE_CYCLES   = 62500000,
    parameter int         GAP_CYCLES      = 62500000,
    parameter logic [7:0] HEADER_BYTE     = frame_tx_scheduler_pkg::HEADER_BYTE
) (
    input  logic              Clk,
    input  logic              i_Rst_n,
    input  logic              i_Enable,
    input  logic              i_VS,
    output logic              o_Write_Inhibit,
    output logic              o_Rd_En,
    output logic [ADDR_W-1:0] o_Rd_Addr,
    input  logic [7:0]        i_Rd_Data,
    output logic              o_Tx_Start,
    output logic [7:0]        o_Tx_Byte,
    input  logic              i_Tx_Busy,
    output logic              o_Frame_Indicator,
    output logic              o_Frame_Done,
    output logic              o_Busy
);
    localparam int CNT_MAX = SETTLE_CYCLES > GAP_CYCLES ? SETTLE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        byte_q, byte_d;
    logic              hdr_q, hdr_d, abort_q, abort_d;
    logic              trig, wait_done, last;

    vs_edge_sync u_vs_edge_sync (
        .Clk     (Clk),
        .i_Rst_n (i_Rst_n),
        .i_VS    (i_VS),
        .o_Rise  (trig)
    );

    always_ff @(posedge Clk or negedge i_Rst_n)
        if (!i_Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            byte_q  <= '0;
            hdr_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            byte_q  <= byte_d;
            hdr_q   <= hdr_d;
            abort_q <= abort_d;
        end

    // The counter clears on every state entry, so cnt_q==0 also marks the
    // first WAIT_TX cycle, where the UART has not yet raised busy.
    assign wait_done = state_q == WAIT_TX && cnt_q != '0 && !i_Tx_Busy;
    assign last      = addr_q == ADDR_W'(BYTES_PER_FRAME - 1);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        byte_d       = byte_q;
        hdr_d        = hdr_q;
        abort_d      = state_q == WAIT_TX && (abort_q || !i_Enable);
        o_Tx_Start   = 1'b0;
        o_Frame_Done = 1'b0;
        case (state_q)
            IDLE:    if (trig && i_Enable) state_d = SETTLE;
            SETTLE:
                if (!i_Enable) state_d = IDLE;
                else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = HEADER;
                    byte_d  = HEADER_BYTE;
                end
            HEADER:
                if (!i_Tx_Busy) begin
                    o_Tx_Start = 1'b1;
                    hdr_d      = 1'b1;
                    state_d    = WAIT_TX;
                end
            FETCH:   state_d = LATCH;
            LATCH: begin
                byte_d  = i_Rd_Data;
                state_d = SEND;
            end
            SEND:
                if (!i_Tx_Busy) begin
                    o_Tx_Start = 1'b1;
                    state_d    = WAIT_TX;
                end
            WAIT_TX:
                if (wait_done) begin
                    hdr_d = 1'b0;
                    if (abort_d) begin
                        state_d = IDLE;
                        addr_d  = '0;
                    end else if (hdr_q) begin
                        state_d = FETCH;
                        addr_d  = '0;
                    end else if (last) begin
                        o_Frame_Done = 1'b1;
                        state_d      = GAP;
                        addr_d       = '0;
                    end else begin
                        state_d = FETCH;
                        addr_d  = addr_q + 1'b1;
                    end
                end
            GAP:     if (!i_Enable || cnt_q == CNT_W'(GAP_CYCLES - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_d = state_d != state_q ? '0 : cnt_q == CNT_W'(CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    assign o_Write_Inhibit   = state_q != IDLE;
    assign o_Busy            = state_q != IDLE;
    assign o_Frame_Indicator = state_q == IDLE;
    assign o_Rd_En           = state_q == FETCH;
    assign o_Rd_Addr         = addr_q;
    assign o_Tx_Byte         = byte_q;
endmodule

// File: tb/tb_frame_tx_scheduler.sv
// tb_frame_tx_scheduler: directed table-driven bench with a RAM model and a 20-cycle UART busy model
module tb_frame_tx_scheduler;
    localparam int BPF = 4;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b1;
    logic          vs = 1'b0;
    logic          hold_busy = 1'b0;
    logic          inhibit, rd_en, tx_start, indicator, frame_done, busy_o, tx_busy;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data = 8'h00;
    logic [7:0]    tx_byte;
    logic [7:0]    ram [BPF];
    int            busy_cnt = 0;
    int            cyc = 0;
    int            starts = 0;
    int            dones = 0;
    int            first_start_cyc = -1;
    logic [7:0]    txq [$];
    int            vec = 0;
    int            err = 0;

    frame_tx_scheduler #(
        .BYTES_PER_FRAME (BPF),
        .ADDR_W          (AW),
        .SETTLE_CYCLES   (10),
        .GAP_CYCLES      (8),
        .HEADER_BYTE     (8'hFF)
    ) dut (
        .Clk               (clk),
        .i_Rst_n           (rst_n),
        .i_Enable          (en),
        .i_VS              (vs),
        .o_Write_Inhibit   (inhibit),
        .o_Rd_En           (rd_en),
        .o_Rd_Addr         (rd_addr),
        .i_Rd_Data         (rd_data),
        .o_Tx_Start        (tx_start),
        .o_Tx_Byte         (tx_byte),
        .i_Tx_Busy         (tx_busy),
        .o_Frame_Indicator (indicator),
        .o_Frame_Done      (frame_done),
        .o_Busy            (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_data <= ram[rd_addr[1:0]];
        if (tx_start) busy_cnt <= 20;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0) | hold_busy;

    always @(negedge clk) begin
        if (tx_start) begin
            starts++;
            txq.push_back(tx_byte);
            if (first_start_cyc < 0) first_start_cyc = cyc;
        end
        if (frame_done) dones++;
    end

    typedef struct {
        logic [31:0] ram_word;
        logic [39:0] exp_bytes;
    } vec_t;
    vec_t tbl [3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_vs();
        @(negedge clk);
        vs = 1'b1;
        repeat (3) @(negedge clk);
        vs = 1'b0;
    endtask

    task automatic wait_starts(input int n, input string nm);
        int k = 0;
        while (starts < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_timeout"}, k < 500, 1);
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_done && k < 400);
        chk({nm, "_done_timeout"}, frame_done, 1);
    endtask

    task automatic load_ram(input logic [31:0] w);
        for (int i = 0; i < BPF; i++) ram[i] = w[8*i +: 8];
    endtask

    initial begin
        int s0, d0, q0, bad, vs_cyc;
        logic [7:0] held;
        tbl[0] = '{32'hC3_5A_A5_3C, 40'hC3_5A_A5_3C_FF};
        tbl[1] = '{32'h00_FF_01_80, 40'h00_FF_01_80_FF};
        tbl[2] = '{32'h12_34_56_78, 40'h12_34_56_78_FF};
        load_ram(tbl[0].ram_word);

        repeat (3) @(negedge clk);
        chk("rst_indicator", indicator, 1);
        chk("rst_inhibit", inhibit, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_tx_byte", tx_byte, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            load_ram(tbl[v].ram_word);
            s0 = starts;
            d0 = dones;
            txq.delete();
            first_start_cyc = -1;
            vs_cyc = cyc + 1;
            pulse_vs();
            chk("inhibit_after_vs", inhibit, 1);
            chk("indicator_in_frame", indicator, 0);
            wait_done("tbl");
            for (int i = 1; i <= 9; i++) begin
                @(negedge clk);
                if (i == 8) chk("inhibit_gap_end", inhibit, 1);
                if (i == 9) begin
                    chk("inhibit_after_gap", inhibit, 0);
                    chk("indicator_after_gap", indicator, 1);
                end
            end
            chk("tbl_latency_11_13", (first_start_cyc - vs_cyc) >= 11 && (first_start_cyc - vs_cyc) <= 13, 1);
            chk("tbl_starts", starts - s0, 5);
            chk("tbl_dones", dones - d0, 1);
            chk("tbl_qsize", txq.size(), 5);
            for (int i = 0; i < 5; i++)
                chk("tbl_byte", txq.size() > i ? txq[i] : 8'hxx, tbl[v].exp_bytes[8*i +: 8]);
        end

        load_ram(tbl[0].ram_word);
        s0 = starts;
        d0 = dones;
        q0 = txq.size();
        pulse_vs();
        wait_starts(s0 + 2, "vs_send");
        pulse_vs();
        wait_done("vs_send");
        pulse_vs();
        repeat (20) @(negedge clk);
        chk("vs_ignored_starts", starts - s0, 5);
        chk("vs_ignored_dones", dones - d0, 1);
        chk("vs_ignored_idle", indicator, 1);
        pulse_vs();
        wait_done("vs_restart");
        repeat (12) @(negedge clk);
        chk("vs_restart_starts", starts - s0, 10);
        chk("vs_restart_hdr", txq.size() > q0 + 5 ? txq[q0 + 5] : 8'hxx, 8'hFF);

        s0 = starts;
        d0 = dones;
        pulse_vs();
        wait_starts(s0 + 3, "abort");
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_byte_finishing", busy_o, 1);
        repeat (40) @(negedge clk);
        chk("abort_idle", indicator, 1);
        chk("abort_inhibit", inhibit, 0);
        chk("abort_addr", rd_addr, 0);
        chk("abort_starts", starts - s0, 3);
        chk("abort_no_done", dones - d0, 0);
        en = 1'b1;
        repeat (3) @(negedge clk);

        s0 = starts;
        pulse_vs();
        wait_done("rst_gap");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstgap_inhibit", inhibit, 0);
        chk("rstgap_indicator", indicator, 1);
        chk("rstgap_busy", busy_o, 0);
        chk("rstgap_addr", rd_addr, 0);
        chk("rstgap_tx_byte", tx_byte, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        s0 = starts;
        q0 = txq.size();
        pulse_vs();
        wait_starts(s0 + 1, "rstgap_restart");
        chk("rstgap_restart_hdr", txq.size() > q0 ? txq[q0] : 8'hxx, 8'hFF);
        wait_done("rstgap_restart");
        repeat (12) @(negedge clk);

        s0 = starts;
        d0 = dones;
        q0 = txq.size();
        pulse_vs();
        wait_starts(s0 + 2, "hold");
        @(negedge clk);
        hold_busy = 1'b1;
        repeat (25) @(negedge clk);
        held = tx_byte;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_start || tx_byte !== held) bad++;
        end
        chk("hold_no_start_stable", bad, 0);
        chk("hold_starts", starts - s0, 2);
        hold_busy = 1'b0;
        wait_done("hold");
        repeat (12) @(negedge clk);
        chk("hold_total_starts", starts - s0, 5);
        chk("hold_dones", dones - d0, 1);
        chk("hold_last_byte", txq.size() > q0 + 4 ? txq[q0 + 4] : 8'hxx, 8'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
